// File: rtl/conv3x3_stream.sv
// Sequential 3x3 valid convolution over a latched 16x16 padded map. The 14x14
// results stream out in row-major order under a valid/ready handshake.
module conv3x3_stream #(
  parameter bit RELU = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [0:1023] input_matrix,
  input  logic [0:35]   kernel,
  output logic [11:0]   out_data,
  output logic [3:0]    out_row,
  output logic [3:0]    out_col,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg;
  logic [0:1023]     map_reg;
  logic [0:35]       kern_reg;
  logic [3:0]        row_reg;
  logic [3:0]        col_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              done_reg;
  logic signed [8:0] prod [9];
  logic signed [11:0] sum;

  // One 9-bit product per tap; row/col stay <= 13, so the +2 offset fits 4 bits.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_krow
      for (genvar gj = 0; gj < 3; gj++) begin : g_kcol
        logic [3:0] pix_row;
        logic [3:0] pix_col;
        logic [9:0] pix_idx;
        logic [3:0] pix;
        logic [3:0] wt;
        assign pix_row = row_reg + 4'(gi);
        assign pix_col = col_reg + 4'(gj);
        assign pix_idx = {pix_row, pix_col, 2'b00};
        assign pix     = map_reg[pix_idx +: 4];
        assign wt      = kern_reg[(gi*3+gj)*4 +: 4];
        assign prod[gi*3+gj] = $signed({5'b00000, pix}) * $signed({{5{wt[3]}}, wt});
      end
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) begin
      sum = sum + $signed({{3{prod[k][8]}}, prod[k]});
    end
  end

  assign out_data  = (RELU && sum[11]) ? 12'd0 : sum;
  assign out_row   = row_reg;
  assign out_col   = col_reg;
  assign out_valid = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      map_reg   <= '0;
      kern_reg  <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            map_reg   <= input_matrix;
            kern_reg  <= kernel;
            row_reg   <= '0;
            col_reg   <= '0;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (col_reg == 4'd13) begin
              // Last position keeps the counters at (13,13) while leaving RUN.
              if (row_reg == 4'd13) begin
                state_reg <= DONE;
                valid_reg <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                col_reg <= '0;
                row_reg <= row_reg + 4'd1;
              end
            end else begin
              col_reg <= col_reg + 4'd1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
